ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Purpose : arbitrates an instruction port and a data port onto one single-ported RAM window.
// Latency : grant and RAM strobe are combinational in the request cycle; the response follows one cycle later.
// Backpressure: the losing requester holds its request; data wins after STARVE_LIMIT denied cycles.
//
// Ports:
//   clk_sys, rst_sys_n                 clock and async active-low reset
//   instr_req/addr -> instr_gnt        instruction request, read-only, full-word
//   instr_rvalid/rdata/err             instruction response, one cycle after grant
//   data_req/we/be/addr/wdata -> gnt   data request, read or byte-masked write
//   data_rvalid/rdata/err              data response, one cycle after grant
//   mem_req/write/be/addr/wdata        RAM strobe, driven only for in-window grants
//   mem_rdata                          RAM read data, valid the cycle after mem_req
module ram_port_arbiter #(
  parameter int unsigned MEM_SIZE     = 65536,
  parameter logic [31:0] MEM_START    = 32'h0000_0000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,

  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  output logic [31:0] instr_rdata,
  output logic        instr_err,

  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err,

  output logic        mem_req,
  output logic        mem_write,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_MASK = ~(32'(MEM_SIZE) - 32'd1);
  localparam logic [3:0]  STARVE_TH = 4'(STARVE_LIMIT);

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  logic [3:0]  starve_cnt;
  logic        resp_valid;
  owner_e      resp_owner;
  logic        resp_err;

  logic        data_win;
  logic        instr_win;
  logic        grant_any;
  logic [31:0] gnt_addr;
  logic        in_range;
  logic        mem_hit;
  logic [31:0] resp_rdata;

  // Grants are gated by reset so nothing is accepted while the block is held in reset.
  always_comb begin
    data_win  = rst_sys_n && data_req && (!instr_req || (starve_cnt >= STARVE_TH));
    instr_win = rst_sys_n && instr_req && !data_win;
    grant_any = instr_win || data_win;
    gnt_addr  = data_win ? data_addr : instr_addr;
    in_range  = ((gnt_addr & ADDR_MASK) == MEM_START);
    mem_hit   = grant_any && in_range;
  end

  assign instr_gnt = instr_win;
  assign data_gnt  = data_win;

  // RAM outputs are forced to zero unless an in-window access is granted, so
  // out-of-window grants never disturb the RAM.
  always_comb begin
    mem_req   = mem_hit;
    mem_write = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (mem_hit) begin
      mem_addr = gnt_addr;
      if (data_win) begin
        mem_write = data_we;
        mem_be    = data_be;
        mem_wdata = data_wdata;
      end else begin
        mem_be    = 4'hF;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      resp_valid <= 1'b0;
      resp_owner <= OWN_INSTR;
      resp_err   <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      resp_valid <= grant_any;
      resp_owner <= data_win ? OWN_DATA : OWN_INSTR;
      resp_err   <= grant_any && !in_range;
      // Counts consecutive cycles data waited; any data grant or dropped request restarts it.
      if (data_req && !data_win) begin
        if (starve_cnt != 4'hF) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

  // Error responses return zero data; otherwise the RAM read data passes straight through.
  assign resp_rdata   = resp_err ? 32'h0 : mem_rdata;

  assign instr_rvalid = resp_valid && (resp_owner == OWN_INSTR);
  assign data_rvalid  = resp_valid && (resp_owner == OWN_DATA);
  assign instr_rdata  = instr_rvalid ? resp_rdata : 32'h0;
  assign data_rdata   = data_rvalid  ? resp_rdata : 32'h0;
  assign instr_err    = instr_rvalid && resp_err;
  assign data_err     = data_rvalid  && resp_err;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Purpose : directed self-checking bench for ram_port_arbiter with a response scoreboard.
// Latency : expects grants in the request cycle and responses one cycle later.
// Backpressure: requests are held by the bench while the model predicts a loss.
module tb_ram_port_arbiter;

  localparam int S_LIM = 4;

  logic        clk_sys;
  logic        rst_sys_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        mem_req;
  logic        mem_write;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  ram_port_arbiter #(
    .MEM_SIZE     (65536),
    .MEM_START    (32'h0000_0000),
    .STARVE_LIMIT (S_LIM)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_gnt    (instr_gnt),
    .instr_rvalid (instr_rvalid),
    .instr_rdata  (instr_rdata),
    .instr_err    (instr_err),
    .data_req     (data_req),
    .data_we      (data_we),
    .data_be      (data_be),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_gnt     (data_gnt),
    .data_rvalid  (data_rvalid),
    .data_rdata   (data_rdata),
    .data_err     (data_err),
    .mem_req      (mem_req),
    .mem_write    (mem_write),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        vld;
    logic        own_d;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t       sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_starve = 0;
  logic [31:0] pend_rd = 32'h0;
  logic        last_dgnt = 1'b0;

  // RAM contents seen by the bench: a fixed opcode at 0x100, an address-derived pattern elsewhere.
  function automatic logic [31:0] ram_val(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0293;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ":instr_gnt"},    32'(instr_gnt),    32'h0);
    chk({tag, ":data_gnt"},     32'(data_gnt),     32'h0);
    chk({tag, ":mem_req"},      32'(mem_req),      32'h0);
    chk({tag, ":instr_rvalid"}, 32'(instr_rvalid), 32'h0);
    chk({tag, ":data_rvalid"},  32'(data_rvalid),  32'h0);
    chk({tag, ":instr_rdata"},  instr_rdata,       32'h0);
    chk({tag, ":data_rdata"},   data_rdata,        32'h0);
    chk({tag, ":instr_err"},    32'(instr_err),    32'h0);
    chk({tag, ":data_err"},     32'(data_err),     32'h0);
  endtask

  // Drive one request cycle, check the same-cycle grant and RAM strobe, and queue the expected response.
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [3:0] db, input logic [31:0] da, input logic [31:0] dwd);
    logic        exp_d, exp_i, any, inr, hit;
    logic [31:0] a;
    resp_t       e;
    instr_req  = ir;
    instr_addr = ia;
    data_req   = dr;
    data_we    = dw;
    data_be    = db;
    data_addr  = da;
    data_wdata = dwd;
    #1;
    exp_d = dr && (!ir || (m_starve >= S_LIM));
    exp_i = ir && !exp_d;
    any   = exp_i || exp_d;
    a     = exp_d ? da : ia;
    inr   = ((a & 32'hFFFF_0000) == 32'h0);
    hit   = any && inr;
    chk("instr_gnt", 32'(instr_gnt), 32'(exp_i));
    chk("data_gnt",  32'(data_gnt),  32'(exp_d));
    chk("mem_req",   32'(mem_req),   32'(hit));
    chk("mem_write", 32'(mem_write), 32'(hit && exp_d && dw));
    chk("mem_be",    32'(mem_be),    hit ? (exp_d ? 32'(db) : 32'hF) : 32'h0);
    chk("mem_addr",  mem_addr,       hit ? a : 32'h0);
    chk("mem_wdata", mem_wdata,      (hit && exp_d) ? dwd : 32'h0);
    last_dgnt = data_gnt;
    e.vld   = any;
    e.own_d = exp_d;
    e.err   = any && !inr;
    e.rdata = hit ? ram_val(a) : 32'h0;
    sb.push_back(e);
    pend_rd = hit ? ram_val(a) : 32'hBAD0_BAD0;
    if (dr && !exp_d) m_starve = (m_starve == 15) ? 15 : m_starve + 1;
    else              m_starve = 0;
  endtask

  // Advance one clock, present the RAM read data, and compare the response against the scoreboard.
  task automatic advance();
    resp_t e;
    @(posedge clk_sys);
    mem_rdata = pend_rd;
    #1;
    chk("sb_empty", 32'(sb.size() == 0), 32'h0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("instr_rvalid", 32'(instr_rvalid), 32'(e.vld && !e.own_d));
      chk("data_rvalid",  32'(data_rvalid),  32'(e.vld && e.own_d));
      chk("both_rvalid",  32'(instr_rvalid && data_rvalid), 32'h0);
      chk("instr_rdata",  instr_rdata, (e.vld && !e.own_d) ? e.rdata : 32'h0);
      chk("data_rdata",   data_rdata,  (e.vld && e.own_d)  ? e.rdata : 32'h0);
      chk("instr_err",    32'(instr_err), 32'(e.vld && !e.own_d && e.err));
      chk("data_err",     32'(data_err),  32'(e.vld && e.own_d && e.err));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with requests asserted: nothing may be granted or reported.
    rst_sys_n  = 1'b0;
    instr_req  = 1'b1;
    instr_addr = 32'h0000_0100;
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_be    = 4'hF;
    data_addr  = 32'h0000_0200;
    data_wdata = 32'h1234_5678;
    mem_rdata  = 32'hFFFF_FFFF;
    #2;
    chk_idle("reset");
    repeat (2) @(posedge clk_sys);
    #1;
    chk_idle("reset_hold");
    rst_sys_n = 1'b1;

    // Single instruction fetch in the first cycle after release.
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    advance();

    // Both ports held: four instruction grants then one data grant, repeating.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h0000_0104, 1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
      chk("starve_pattern", 32'(last_dgnt), 32'((i % 5) == 4));
      advance();
    end

    // Byte-masked data write.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'hDEAD_BEEF);
    advance();

    // Out-of-window data read and instruction fetch.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
    advance();
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    advance();

    // Alternating single-port grants, back to back.
    for (int i = 0; i < 8; i++) begin
      if ((i % 2) == 0) drive(1'b1, 32'h0000_0400 + 32'(i * 4), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      else              drive(1'b0, 32'h0, 1'b1, (i % 4) == 3, 4'b1100, 32'h0000_0800 + 32'(i * 4), 32'h0A0B_0C0D);
      advance();
    end

    // Idle cycle: no response expected.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    advance();

    // Reset lands after a data grant: the pending response must vanish.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0204, 32'h0);
    @(negedge clk_sys);
    rst_sys_n = 1'b0;
    sb.delete();
    m_starve = 0;
    #1;
    chk_idle("mid_reset");
    data_req = 1'b0;
    mem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_sys);
      #1;
      chk_idle("mid_reset_hold");
    end
    rst_sys_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      advance();
    end

    // Normal service resumes after the mid-transaction reset.
    drive(1'b1, 32'h0000_0100, 1'b1, 1'b1, 4'b0101, 32'h0000_0208, 32'h0F0F_0F0F);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0101, 32'h0000_0208, 32'h0F0F_0F0F);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
